ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage; producer side of the decode interface. Owns the PC and fetches from instruction memory over a req/ack handshake.
- Presents Instruction and opcplus4 to decode/control with a valid/ready handshake.
- Resolves beq/bne/j/jal/jr using decode's read_data_1 and Sign_extend and control's flags when the instruction is consumed. No delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_AW, 14, instruction memory word-address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- Instruction  output  32  held instruction to decode/control.
- opcplus4  output  32  pc+4 of the held instruction, used by jal writeback.
- inst_valid  output  1  Instruction and opcplus4 are valid.
- inst_ready  input  1  decode consumes the instruction in this cycle.
- Branch  input  1  beq.
- nBranch  input  1  bne.
- Jmp  input  1  j.
- Jal  input  1  jal.
- Jr  input  1  jr.
- Zero  input  1  ALU equality result for the held instruction.
- read_data_1  input  32  rs value, the jr target.
- Sign_extend  input  32  branch offset, already shifted left by 2 for beq/bne.
- pc_out  output  32  PC of the held instruction, for debug.
- retired  output  32  count of consumed instructions.
- misalign_err  output  1  sticky flag: jr target had nonzero bits [1:0].

Behaviour:
- Reset (async, any cycle, mid-fetch included):
  - pc=RESET_PC, state=FETCH.
  - Instruction=0, opcplus4=RESET_PC+4, inst_valid=0, retired=0, misalign_err=0.
  - imem_req is 0 while reset is asserted and 1 on the first cycle after release.
  - Instruction memory shares this reset, so no stale ack can arrive.
- FSM has two states, FETCH and HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc[IMEM_AW+1:2], inst_valid=0.
  - When imem_ack=1: latch Instruction=imem_rdata and opcplus4=pc+4, then go to HOLD.
  - Minimum latency: an ack in the first FETCH cycle gives inst_valid=1 in the next cycle.
- HOLD:
  - inst_valid=1, imem_req=0; Instruction and opcplus4 stay stable.
  - When inst_ready=0, stay in HOLD; control inputs are ignored.
  - When inst_ready=1: load pc=next_pc, increment retired (wraps 2^32-1 to 0), go to FETCH. Back-to-back throughput is therefore 1 instruction per 2 cycles minimum.
- imem_ack in HOLD is a protocol error: ignored, no state change.
- next_pc priority, highest first:
  1. Jr: {read_data_1[31:2],2'b00}. If read_data_1[1:0]!=0, set misalign_err; it stays set until reset.
  2. Jmp or Jal: {opcplus4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch && Zero) or (nBranch && !Zero): opcplus4 + Sign_extend.
  4. Otherwise: opcplus4.
- Several flags asserted together are resolved by the priority above; no error is raised.
- All PC arithmetic is 32-bit modulo 2^32 and wraps silently: pc=FFFF_FFFC gives opcplus4=0, and a negative branch offset below 0 wraps.
- imem_addr uses only pc[IMEM_AW+1:2]; upper PC bits are ignored for memory.
- All outputs are registered except imem_req, imem_addr and inst_valid, which decode from state and pc.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010, OP_JAL=6'b000011;
  - FSM state typedef fetch_state_t {FETCH, HOLD};
  - RESET_PC default.
- One natural sub-module, npc_calc: purely combinational next-PC mux implementing the priority and misalignment check above. The rest (FSM, PC/instruction registers, counter) stays in ifetch_unit.

Test Plan:
- Reset then zero-latency ack: release reset, memory acks in the first FETCH cycle with rdata=32'h2008_0005 -> next cycle inst_valid=1, Instruction=2008_0005, opcplus4=4, pc_out=0; inst_ready=1 -> imem_addr=1 next cycle, retired=1.
- Stall both sides: ack delayed 3 cycles, then inst_ready low 4 cycles -> imem_req high for exactly 4 cycles; Instruction stable through HOLD; retired unchanged until accept.
- Branches at pc=0x40 with Sign_extend=FFFF_FFF0:
  - Branch=1, Zero=1 -> next imem_addr=(0x34>>2)=0x0D.
  - Branch=1, Zero=0 -> next address 0x44.
  - nBranch=1, Zero=0 -> next address 0x34.
- Jumps at pc=0x1000_0008: Jal=1, Instruction[25:0]=26'h40 -> opcplus4=1000_000C, next pc=1000_0100. Then Jr=1, Jmp=1, read_data_1=0000_0203 -> next pc=0000_0200 (Jr wins) and misalign_err=1, still set after the next accept.
- Reset mid-fetch: assert reset during FETCH with an ack pending -> inst_valid, retired and misalign_err clear immediately; after release, fetch restarts at RESET_PC; pc=FFFF_FFFC fetch gives opcplus4=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM states, control-flag bundle and reset PC.
package cpu_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Control flags from decode/control for the held instruction
  typedef struct packed {
    logic jr;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
    logic zero;
  } ctl_flags_t;

  // Pseudo-direct jump target: region bits of pc+4 with the word index
  function automatic logic [31:0] jump_target(input logic [31:0] opcplus4,
                                              input logic [25:0] instr_index);
    return {opcplus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
module npc_calc
  import cpu_pkg::*;
(
  input  ctl_flags_t  flags_i,
  input  logic [31:0] opcplus4_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] read_data_1_i,
  input  logic [31:0] sign_extend_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic branch_taken;

  assign branch_taken = (flags_i.branch && flags_i.zero) ||
                        (flags_i.nbranch && !flags_i.zero);

  always_comb begin
    next_pc_o  = opcplus4_i;
    misalign_o = 1'b0;
    if (flags_i.jr) begin
      next_pc_o  = {read_data_1_i[31:2], 2'b00};
      misalign_o = |read_data_1_i[1:0];
    end else if (flags_i.jmp || flags_i.jal) begin
      next_pc_o = jump_target(opcplus4_i, instr_index_i);
    end else if (branch_taken) begin
      next_pc_o = opcplus4_i + sign_extend_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and hands
// instructions to decode over valid/ready, resolving control flow on accept.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction,
  output logic [31:0]        opcplus4,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  input  logic [31:0]        read_data_1,
  input  logic [31:0]        Sign_extend,
  output logic [31:0]        pc_out,
  output logic [31:0]        retired,
  output logic               misalign_err
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  opcplus4_q;
  logic [31:0]  retired_q;
  logic         misalign_q;

  ctl_flags_t   flags;
  logic [31:0]  next_pc;
  logic         jr_misalign;

  assign flags = '{jr:      Jr,
                   jmp:     Jmp,
                   jal:     Jal,
                   branch:  Branch,
                   nbranch: nBranch,
                   zero:    Zero};

  npc_calc u_npc_calc (
    .flags_i       (flags),
    .opcplus4_i    (opcplus4_q),
    .instr_index_i (instr_q[25:0]),
    .read_data_1_i (read_data_1),
    .sign_extend_i (Sign_extend),
    .next_pc_o     (next_pc),
    .misalign_o    (jr_misalign)
  );

  // Fetch FSM with PC, held-instruction, retire counter and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      opcplus4_q <= RESET_PC + 32'd4;
      retired_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q    <= imem_rdata;
            opcplus4_q <= pc_q + 32'd4;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          // Stray acks here are ignored; control flags matter only on accept
          if (inst_ready) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + 32'd1;
            if (jr_misalign) begin
              misalign_q <= 1'b1;
            end
            state_q   <= FETCH;
          end
        end
      endcase
    end
  end

  // Request is gated by reset so memory never sees a request during reset
  assign imem_req     = (state_q == FETCH) && !reset;
  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign inst_valid   = (state_q == HOLD);

  assign Instruction  = instr_q;
  assign opcplus4     = opcplus4_q;
  assign pc_out       = pc_q;
  assign retired      = retired_q;
  assign misalign_err = misalign_q;

endmodule
